coin_return_dispenser: RTL and testbench

Drives the coin-return hopper of the vending machine. It counts the single-coin return requests the vending FSM issues (`returnNickel`, `returnDime`). It then fires the matching hopper solenoid once per owed coin and waits for the drop sensor to confirm each coin before firing the next. It sits between the vending controller's return outputs and the physical hopper/sensor pins.

---
 rtl/coin_return_dispenser_if.sv | 47 ++++
 rtl/coin_return_dispenser.sv | 228 ++++++++++++++++++++++
 tb/tb_coin_return_dispenser.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_return_dispenser_if.sv
// Coin-return hopper bus: request/sensor inputs from the vending side and
// solenoid/status outputs back from the dispenser.
interface coin_return_dispenser_if #(
  parameter int CNT_W = 3
);
  logic             returnNickel;
  logic             returnDime;
  logic             coinSensed;
  logic             clearFault;
  logic             nickelSolenoid;
  logic             dimeSolenoid;
  logic [CNT_W-1:0] pendingNickels;
  logic [CNT_W-1:0] pendingDimes;
  logic             busy;
  logic             fault;
  logic             overflow;

  // Vending controller / hopper-pin side
  modport master (
    output returnNickel,
    output returnDime,
    output coinSensed,
    output clearFault,
    input  nickelSolenoid,
    input  dimeSolenoid,
    input  pendingNickels,
    input  pendingDimes,
    input  busy,
    input  fault,
    input  overflow
  );

  // Dispenser side
  modport slave (
    input  returnNickel,
    input  returnDime,
    input  coinSensed,
    input  clearFault,
    output nickelSolenoid,
    output dimeSolenoid,
    output pendingNickels,
    output pendingDimes,
    output busy,
    output fault,
    output overflow
  );
endinterface

// File: rtl/coin_return_dispenser.sv
// Coin-return dispenser: counts single-coin return requests, then fires the
// matching hopper solenoid once per owed coin and waits for the drop sensor
// before the next coin. Dimes are always served before nickels.
module coin_return_dispenser #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  coin_return_dispenser_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int PW = $clog2(PULSE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [PW-1:0]    PULSE_LAST   = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  // FSM state and its next-state values
  state_t        state_r;
  state_t        state_s;
  logic          sel_r;        // 0 = nickel, 1 = dime
  logic          sel_s;
  logic          seen_r;       // sensor fired during the current pulse
  logic          seen_s;
  logic [PW-1:0] pulse_cnt_r;
  logic [PW-1:0] pulse_cnt_s;
  logic [TW-1:0] wait_cnt_r;
  logic [TW-1:0] wait_cnt_s;
  logic          dec_s;        // current coin confirmed this cycle

  // Request edge detection
  logic          prev_nickel_r;
  logic          prev_dime_r;
  logic          inc_nickel_s;
  logic          inc_dime_s;
  logic          dec_nickel_s;
  logic          dec_dime_s;

  // Owed-coin counters
  logic [CNT_W-1:0] nickels_r;
  logic [CNT_W-1:0] dimes_r;
  logic [CNT_W-1:0] nickels_s;
  logic [CNT_W-1:0] dimes_s;
  logic             ovf_nickel_s;
  logic             ovf_dime_s;
  logic             overflow_r;

  // Registered drive/status outputs
  logic nickel_sol_r;
  logic dime_sol_r;
  logic busy_r;
  logic fault_r;

  // Saturating up/down step; returns {overflow_hit, next_count}. A coinciding
  // increment and decrement cancel, so that case never counts as overflow.
  function automatic logic [CNT_W:0] cnt_update(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             dec
  );
    logic [CNT_W-1:0] nxt;
    logic             ovf;
    nxt = cnt;
    ovf = 1'b0;
    if (inc && !dec) begin
      if (cnt == CNT_MAX) begin
        ovf = 1'b1;
      end else begin
        nxt = cnt + CNT_ONE;
      end
    end else if (dec && !inc) begin
      nxt = cnt - CNT_ONE;
    end else begin
      nxt = cnt;
    end
    return {ovf, nxt};
  endfunction

  // Rising-edge detect on the request lines and routing of the confirmation
  always_comb begin
    inc_nickel_s = bus.returnNickel & ~prev_nickel_r;
    inc_dime_s   = bus.returnDime & ~prev_dime_r;
    dec_nickel_s = dec_s & ~sel_r;
    dec_dime_s   = dec_s & sel_r;
  end

  // Next owed-coin counts
  always_comb begin
    {ovf_nickel_s, nickels_s} = cnt_update(nickels_r, inc_nickel_s, dec_nickel_s);
    {ovf_dime_s, dimes_s}     = cnt_update(dimes_r, inc_dime_s, dec_dime_s);
  end

  // Next-state logic: pick a coin, pulse its solenoid, await the sensor
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    seen_s      = seen_r;
    pulse_cnt_s = pulse_cnt_r;
    wait_cnt_s  = wait_cnt_r;
    dec_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (dimes_r != {CNT_W{1'b0}}) begin
          state_s     = ST_FIRE;
          sel_s       = 1'b1;
          seen_s      = 1'b0;
          pulse_cnt_s = {PW{1'b0}};
        end else if (nickels_r != {CNT_W{1'b0}}) begin
          state_s     = ST_FIRE;
          sel_s       = 1'b0;
          seen_s      = 1'b0;
          pulse_cnt_s = {PW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FIRE: begin
        if (pulse_cnt_r == PULSE_LAST) begin
          // A sense on the last pulse cycle still counts as early confirmation
          if (seen_r || bus.coinSensed) begin
            state_s = ST_IDLE;
            dec_s   = 1'b1;
            seen_s  = 1'b0;
          end else begin
            state_s    = ST_WAIT;
            wait_cnt_s = {TW{1'b0}};
          end
        end else begin
          pulse_cnt_s = pulse_cnt_r + PW'(1);
          if (bus.coinSensed) begin
            seen_s = 1'b1;
          end else begin
            seen_s = seen_r;
          end
        end
      end
      ST_WAIT: begin
        if (bus.coinSensed) begin
          state_s = ST_IDLE;
          dec_s   = 1'b1;
        end else if (wait_cnt_r == TIMEOUT_LAST) begin
          state_s = ST_FAULT;
        end else begin
          wait_cnt_s = wait_cnt_r + TW'(1);
        end
      end
      ST_FAULT: begin
        // The failed coin is still owed, so IDLE naturally retries it
        if (bus.clearFault) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, coin select and timers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      sel_r       <= 1'b0;
      seen_r      <= 1'b0;
      pulse_cnt_r <= {PW{1'b0}};
      wait_cnt_r  <= {TW{1'b0}};
    end else begin
      state_r     <= state_s;
      sel_r       <= sel_s;
      seen_r      <= seen_s;
      pulse_cnt_r <= pulse_cnt_s;
      wait_cnt_r  <= wait_cnt_s;
    end
  end

  // Request history, owed counts and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_nickel_r <= 1'b0;
      prev_dime_r   <= 1'b0;
      nickels_r     <= {CNT_W{1'b0}};
      dimes_r       <= {CNT_W{1'b0}};
      overflow_r    <= 1'b0;
    end else begin
      prev_nickel_r <= bus.returnNickel;
      prev_dime_r   <= bus.returnDime;
      nickels_r     <= nickels_s;
      dimes_r       <= dimes_s;
      overflow_r    <= overflow_r | ovf_nickel_s | ovf_dime_s;
    end
  end

  // Outputs registered from the next state so they align with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nickel_sol_r <= 1'b0;
      dime_sol_r   <= 1'b0;
      busy_r       <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      nickel_sol_r <= (state_s == ST_FIRE) && !sel_s;
      dime_sol_r   <= (state_s == ST_FIRE) && sel_s;
      busy_r       <= (state_s == ST_FIRE) || (state_s == ST_WAIT);
      fault_r      <= (state_s == ST_FAULT);
    end
  end

  assign bus.nickelSolenoid = nickel_sol_r;
  assign bus.dimeSolenoid   = dime_sol_r;
  assign bus.pendingNickels = nickels_r;
  assign bus.pendingDimes   = dimes_r;
  assign bus.busy           = busy_r;
  assign bus.fault          = fault_r;
  assign bus.overflow       = overflow_r;

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Bench for coin_return_dispenser: directed scenarios with hand-computed
// expectations plus randomized traffic, all checked every cycle against a
// coin-schedule model of the dispenser.
module tb_coin_return_dispenser;

  localparam int P    = 4;
  localparam int T    = 16;
  localparam int MAXC = 7;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  bit   cmp_en;

  coin_return_dispenser_if #(.CNT_W(3)) bus();

  coin_return_dispenser #(
    .PULSE_CYCLES  (P),
    .TIMEOUT_CYCLES(T),
    .CNT_W         (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: owed counts plus the coin currently being served. m_act is 0 when
  // no coin is in flight, 1 while one is being served, 2 after a timeout.
  // m_age is the 1-based cycle of the current attempt: 1..P pulse, then wait.
  int m_mn, m_md, m_ovf, m_pn, m_pd, m_act, m_age, m_coin, m_seen;

  always @(posedge clk or negedge rst_n) begin : model
    int t_mn, t_md, t_ovf, t_act, t_age, t_coin, t_seen;
    int dn, dd, inn, ind, sense;
    if (!rst_n) begin
      m_mn <= 0; m_md <= 0; m_ovf <= 0; m_pn <= 0; m_pd <= 0;
      m_act <= 0; m_age <= 0; m_coin <= 0; m_seen <= 0;
    end else begin
      sense  = int'(bus.coinSensed);
      t_act  = m_act; t_age = m_age; t_coin = m_coin; t_seen = m_seen;
      dn = 0; dd = 0;
      if (m_act == 0) begin
        if (m_md > 0) begin
          t_act = 1; t_age = 1; t_coin = 1; t_seen = 0;
        end else if (m_mn > 0) begin
          t_act = 1; t_age = 1; t_coin = 0; t_seen = 0;
        end
      end else if (m_act == 1) begin
        if (m_age <= P) begin
          t_seen = m_seen | sense;
          if (m_age == P && t_seen != 0) begin
            t_act = 0;
            if (m_coin == 1) dd = 1; else dn = 1;
          end else begin
            t_age = m_age + 1;
          end
        end else if (sense != 0) begin
          t_act = 0;
          if (m_coin == 1) dd = 1; else dn = 1;
        end else if (m_age == P + T) begin
          t_act = 2;
        end else begin
          t_age = m_age + 1;
        end
      end else if (bus.clearFault) begin
        t_act = 0;
      end
      inn = (bus.returnNickel && m_pn == 0) ? 1 : 0;
      ind = (bus.returnDime && m_pd == 0) ? 1 : 0;
      t_mn = m_mn; t_md = m_md; t_ovf = m_ovf;
      if (inn == 1 && dn == 0) begin
        if (m_mn == MAXC) t_ovf = 1; else t_mn = m_mn + 1;
      end else if (dn == 1 && inn == 0) begin
        t_mn = m_mn - 1;
      end
      if (ind == 1 && dd == 0) begin
        if (m_md == MAXC) t_ovf = 1; else t_md = m_md + 1;
      end else if (dd == 1 && ind == 0) begin
        t_md = m_md - 1;
      end
      m_mn <= t_mn; m_md <= t_md; m_ovf <= t_ovf;
      m_pn <= int'(bus.returnNickel); m_pd <= int'(bus.returnDime);
      m_act <= t_act; m_age <= t_age; m_coin <= t_coin; m_seen <= t_seen;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("nickelSolenoid", int'(bus.nickelSolenoid),
          (m_act == 1 && m_age <= P && m_coin == 0) ? 1 : 0);
      chk("dimeSolenoid", int'(bus.dimeSolenoid),
          (m_act == 1 && m_age <= P && m_coin == 1) ? 1 : 0);
      chk("pendingNickels", int'(bus.pendingNickels), m_mn);
      chk("pendingDimes", int'(bus.pendingDimes), m_md);
      chk("busy", int'(bus.busy), (m_act == 1) ? 1 : 0);
      chk("fault", int'(bus.fault), (m_act == 2) ? 1 : 0);
      chk("overflow", int'(bus.overflow), m_ovf);
      chk("solenoid_exclusive", int'(bus.nickelSolenoid & bus.dimeSolenoid), 0);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b0;
    bus.returnNickel = 1'b0;
    bus.returnDime   = 1'b0;
    bus.coinSensed   = 1'b0;
    bus.clearFault   = 1'b0;
    #2;
    chk("rst_nickelSolenoid", int'(bus.nickelSolenoid), 0);
    chk("rst_dimeSolenoid", int'(bus.dimeSolenoid), 0);
    chk("rst_pendingNickels", int'(bus.pendingNickels), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_fault", int'(bus.fault), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    tick(2);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    tick();

    // One nickel, sensed in WAIT cycle 2
    bus.returnNickel = 1'b1; tick();
    chk("s1_count", int'(bus.pendingNickels), 1);
    chk("s1_not_yet_fired", int'(bus.nickelSolenoid), 0);
    bus.returnNickel = 1'b0; tick();
    chk("s1_fire_c1", int'(bus.nickelSolenoid), 1);
    chk("s1_busy", int'(bus.busy), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s1_fire_cn", int'(bus.nickelSolenoid), 1);
    end
    tick();
    chk("s1_wait_sol_off", int'(bus.nickelSolenoid), 0);
    chk("s1_wait_busy", int'(bus.busy), 1);
    tick();
    bus.coinSensed = 1'b1; tick();
    bus.coinSensed = 1'b0;
    chk("s1_done_count", int'(bus.pendingNickels), 0);
    chk("s1_done_idle", int'(bus.busy), 0);

    // Simultaneous nickel and dime: dime first
    bus.returnNickel = 1'b1; bus.returnDime = 1'b1; tick();
    chk("s2_nickels", int'(bus.pendingNickels), 1);
    chk("s2_dimes", int'(bus.pendingDimes), 1);
    bus.returnNickel = 1'b0; bus.returnDime = 1'b0; bus.coinSensed = 1'b1; tick();
    chk("s2_dime_first", int'(bus.dimeSolenoid), 1);
    chk("s2_nickel_held", int'(bus.nickelSolenoid), 0);
    tick(4);
    chk("s2_dime_done", int'(bus.pendingDimes), 0);
    tick();
    chk("s2_nickel_next", int'(bus.nickelSolenoid), 1);
    tick(4);
    bus.coinSensed = 1'b0;
    chk("s2_nickel_done", int'(bus.pendingNickels), 0);
    chk("s2_dime_zero", int'(bus.pendingDimes), 0);

    // Dime with no sense: timeout, clear, retry
    bus.returnDime = 1'b1; tick();
    bus.returnDime = 1'b0; tick();
    chk("s3_fire", int'(bus.dimeSolenoid), 1);
    tick(19);
    chk("s3_no_fault_yet", int'(bus.fault), 0);
    tick();
    chk("s3_fault", int'(bus.fault), 1);
    chk("s3_still_owed", int'(bus.pendingDimes), 1);
    bus.clearFault = 1'b1; tick();
    bus.clearFault = 1'b0;
    chk("s3_cleared", int'(bus.fault), 0);
    tick();
    chk("s3_retry_c1", int'(bus.dimeSolenoid), 1);
    bus.coinSensed = 1'b1; tick();
    bus.coinSensed = 1'b0;
    chk("s3_retry_c2", int'(bus.dimeSolenoid), 1);
    tick(2);
    chk("s3_retry_c4", int'(bus.dimeSolenoid), 1);
    tick();
    chk("s3_retry_off", int'(bus.dimeSolenoid), 0);
    chk("s3_retry_done", int'(bus.pendingDimes), 0);

    // Sense in 3rd pulse cycle: no WAIT state
    bus.returnNickel = 1'b1; tick();
    bus.returnNickel = 1'b0; tick(3);
    bus.coinSensed = 1'b1; tick();
    bus.coinSensed = 1'b0;
    chk("s4_c4_sol", int'(bus.nickelSolenoid), 1);
    chk("s4_c4_count", int'(bus.pendingNickels), 1);
    tick();
    chk("s4_idle", int'(bus.busy), 0);
    chk("s4_count", int'(bus.pendingNickels), 0);

    // Fault, then held request and saturation
    bus.returnDime = 1'b1; tick();
    bus.returnDime = 1'b0; tick(21);
    chk("s5_fault", int'(bus.fault), 1);
    bus.returnNickel = 1'b1; tick(10);
    bus.returnNickel = 1'b0; tick();
    chk("s5_held_once", int'(bus.pendingNickels), 1);
    for (int i = 0; i < 6; i++) begin
      bus.returnNickel = 1'b1; tick();
      bus.returnNickel = 1'b0; tick();
    end
    chk("s5_sat", int'(bus.pendingNickels), 7);
    chk("s5_no_ovf", int'(bus.overflow), 0);
    bus.returnNickel = 1'b1; tick();
    bus.returnNickel = 1'b0; tick();
    chk("s5_sat_hold", int'(bus.pendingNickels), 7);
    chk("s5_ovf", int'(bus.overflow), 1);

    // Reset in the middle of a dime pulse
    bus.clearFault = 1'b1; tick();
    bus.clearFault = 1'b0; tick(2);
    chk("s6_pre_sol", int'(bus.dimeSolenoid), 1);
    chk("s6_pre_ovf", int'(bus.overflow), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_sol", int'(bus.dimeSolenoid), 0);
    chk("s6_nickels", int'(bus.pendingNickels), 0);
    chk("s6_dimes", int'(bus.pendingDimes), 0);
    chk("s6_busy", int'(bus.busy), 0);
    chk("s6_fault", int'(bus.fault), 0);
    chk("s6_overflow", int'(bus.overflow), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bus.returnNickel = ($urandom_range(0, 7) == 0);
      bus.returnDime   = ($urandom_range(0, 7) == 0);
      bus.coinSensed   = ($urandom_range(0, 5) == 0);
      bus.clearFault   = ($urandom_range(0, 7) == 0);
      tick();
    end
    bus.returnNickel = 1'b0;
    bus.returnDime   = 1'b0;
    bus.coinSensed   = 1'b0;
    bus.clearFault   = 1'b0;
    tick(4);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
